// File: rtl/aq_cp0_vsetvl_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module  : aq_cp0_vsetvl_ctrl_pkg
// Brief   : Shared vector configuration for the CP0 vsetvl sequencer:
//           VLEN/vl width, vtype field positions, SEW/LMUL encodings and
//           the sequencer state encoding.
// Revision: 1.0 - initial release
// ============================================================================
package aq_cp0_vsetvl_ctrl_pkg;

  // Vector register length and the vl register width that can hold VLEN
  localparam int c_vlen = 128;
  localparam int c_vl_w = 8;

  // vtype field positions
  localparam int c_vlmul_lsb = 0;
  localparam int c_vlmul_msb = 1;
  localparam int c_vsew_lsb  = 2;
  localparam int c_vsew_msb  = 4;
  localparam int c_vediv_lsb = 5;
  localparam int c_vediv_msb = 6;
  localparam int c_vill_bit  = 63;

  // SEW encodings (vsew field); 3'b1xx is reserved
  localparam logic [2:0] c_sew_8  = 3'b000;
  localparam logic [2:0] c_sew_16 = 3'b001;
  localparam logic [2:0] c_sew_32 = 3'b010;
  localparam logic [2:0] c_sew_64 = 3'b011;

  // LMUL encodings (vlmul field)
  localparam logic [1:0] c_lmul_1 = 2'b00;
  localparam logic [1:0] c_lmul_2 = 2'b01;
  localparam logic [1:0] c_lmul_4 = 2'b10;
  localparam logic [1:0] c_lmul_8 = 2'b11;

  // vtype value reported when the requested configuration is illegal
  localparam logic [63:0] c_vtype_vill = 64'd1 << c_vill_bit;

  // Sequencer states
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DEC  = 2'd1,
    S_CALC = 2'd2,
    S_WB   = 2'd3
  } vsetvl_state_e;

endpackage : aq_cp0_vsetvl_ctrl_pkg
`default_nettype wire

// File: rtl/aq_cp0_vsetvl_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module  : aq_cp0_vsetvl_ctrl_if
// Brief   : IU request/completion handshake plus CP0 vl/vtype commit bus
//           for the vsetvl sequencer.
// Revision: 1.0 - initial release
// ============================================================================
interface aq_cp0_vsetvl_ctrl_if #(
  parameter int VL_W = 8
);
  // IU -> sequencer
  logic            iui_special_vsetvl;
  logic [63:0]     iui_special_vsetvl_rs1;
  logic [63:0]     iui_special_vsetvl_rs2;
  logic            iui_special_rs1_x0;
  logic            iui_special_vsetvl_dp;
  logic            iui_special_wb_ready;
  logic            iui_special_flush;
  logic            regs_special_vs_off;
  // sequencer -> IU
  logic            special_iui_vsetvl_busy;
  logic            special_iui_vsetvl_cmplt;
  logic            special_iui_vsetvl_expt;
  logic [63:0]     special_iui_vsetvl_wdata;
  // sequencer -> CP0 regs
  logic            special_regs_vsetvl_vld;
  logic            special_regs_vsetvl_dp;
  logic [VL_W-1:0] special_regs_vl;
  logic [63:0]     special_regs_vtype;

  // Environment side (IU and CP0 regs)
  modport master (
    output iui_special_vsetvl, iui_special_vsetvl_rs1, iui_special_vsetvl_rs2,
           iui_special_rs1_x0, iui_special_vsetvl_dp, iui_special_wb_ready,
           iui_special_flush, regs_special_vs_off,
    input  special_iui_vsetvl_busy, special_iui_vsetvl_cmplt,
           special_iui_vsetvl_expt, special_iui_vsetvl_wdata,
           special_regs_vsetvl_vld, special_regs_vsetvl_dp,
           special_regs_vl, special_regs_vtype
  );

  // Sequencer side
  modport slave (
    input  iui_special_vsetvl, iui_special_vsetvl_rs1, iui_special_vsetvl_rs2,
           iui_special_rs1_x0, iui_special_vsetvl_dp, iui_special_wb_ready,
           iui_special_flush, regs_special_vs_off,
    output special_iui_vsetvl_busy, special_iui_vsetvl_cmplt,
           special_iui_vsetvl_expt, special_iui_vsetvl_wdata,
           special_regs_vsetvl_vld, special_regs_vsetvl_dp,
           special_regs_vl, special_regs_vtype
  );
endinterface : aq_cp0_vsetvl_ctrl_if
`default_nettype wire

// File: rtl/aq_cp0_vsetvl_ctrl_vlmax_calc.sv
`default_nettype none
// ============================================================================
// Module  : aq_cp0_vlmax_calc
// Brief   : Combinational vtype legality check and VLMAX computation.
//           Shared with the CP0 vtype CSR-write legality path.
// Revision: 1.0 - initial release
// ============================================================================
module aq_cp0_vlmax_calc
  import aq_cp0_vsetvl_ctrl_pkg::*;
#(
  parameter int VLEN = c_vlen,
  parameter int VL_W = c_vl_w
) (
  input  logic [63:0]     vtype,
  output logic            vill,
  output logic [VL_W-1:0] vlmax
);

  localparam logic [VL_W-1:0] c_vlen_v = VL_W'(VLEN);

  logic [1:0]      w_vlmul;
  logic [2:0]      w_vsew;
  logic [1:0]      w_vediv;
  logic [VL_W-1:0] w_elems;
  logic [VL_W-1:0] w_vlmax_raw;
  logic            w_sew_too_big;

  assign w_vlmul = vtype[c_vlmul_msb:c_vlmul_lsb];
  assign w_vsew  = vtype[c_vsew_msb:c_vsew_lsb];
  assign w_vediv = vtype[c_vediv_msb:c_vediv_lsb];

  // Elements per register = VLEN/SEW, then scaled by the register group size
  assign w_elems     = c_vlen_v >> (32'd3 + 32'(w_vsew));
  assign w_vlmax_raw = w_elems << w_vlmul;

  // SEW wider than one register yields zero elements; unreachable for VLEN>=64
  assign w_sew_too_big = ~w_vsew[2] & (w_elems == '0);

  // Decode legality and gate VLMAX to zero for illegal configurations
  always_comb begin
    vill  = w_vsew[2] | (w_vediv != 2'b00) | (|vtype[63:7]) | w_sew_too_big;
    vlmax = vill ? '0 : w_vlmax_raw;
  end

endmodule : aq_cp0_vlmax_calc
`default_nettype wire

// File: rtl/aq_cp0_vsetvl_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : aq_cp0_vsetvl_ctrl
// Brief   : Multi-cycle vsetvl/vsetvli sequencer. Latches the IU request,
//           decodes vtype, computes the new vl, returns it to the IU and
//           commits vl/vtype to CP0 only on the writeback handshake.
// Revision: 1.0 - initial release
// ============================================================================
module aq_cp0_vsetvl_ctrl
  import aq_cp0_vsetvl_ctrl_pkg::*;
#(
  parameter int VLEN = c_vlen,
  parameter int VL_W = c_vl_w
) (
  input  logic                 forever_cpuclk,
  input  logic                 cpurst_b,
  aq_cp0_vsetvl_ctrl_if.slave  bus
);

  vsetvl_state_e   r_state;
  logic            r_busy;
  logic            r_cmplt;
  logic            r_expt;
  logic            r_dp;
  logic            r_vs_off;
  logic            r_x0;
  logic            r_vill;
  logic [63:0]     r_rs1;
  logic [63:0]     r_rs2;
  logic [63:0]     r_wdata;
  logic [63:0]     r_vtype;
  logic [VL_W-1:0] r_vl;
  logic [VL_W-1:0] r_vlmax;

  logic            w_vill;
  logic [VL_W-1:0] w_vlmax;
  logic [63:0]     w_avl;
  logic            w_avl_ge;
  logic [VL_W-1:0] w_vl;
  logic [63:0]     w_vtype;

  aq_cp0_vlmax_calc #(
    .VLEN (VLEN),
    .VL_W (VL_W)
  ) u_vlmax_calc (
    .vtype (r_rs2),
    .vill  (w_vill),
    .vlmax (w_vlmax)
  );

  // AVL saturates to VLMAX; the compare uses the full 64-bit AVL so that
  // large values with zero low bits still clamp instead of truncating
  assign w_avl    = r_x0 ? {64{1'b1}} : r_rs1;
  assign w_avl_ge = (w_avl >= 64'(r_vlmax));
  assign w_vl     = r_vill ? '0 : (w_avl_ge ? r_vlmax : w_avl[VL_W-1:0]);
  assign w_vtype  = r_vill ? c_vtype_vill : {57'd0, r_rs2[6:0]};

  // Sequencer: IDLE -> DEC -> CALC -> WB, or DEC -> WB when vector unit is off
  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      r_state  <= S_IDLE;
      r_busy   <= 1'b0;
      r_cmplt  <= 1'b0;
      r_expt   <= 1'b0;
      r_dp     <= 1'b0;
      r_vs_off <= 1'b0;
      r_x0     <= 1'b0;
      r_vill   <= 1'b0;
      r_rs1    <= '0;
      r_rs2    <= '0;
      r_wdata  <= '0;
      r_vtype  <= '0;
      r_vl     <= '0;
      r_vlmax  <= '0;
    end else if (bus.iui_special_flush) begin
      r_state <= S_IDLE;
      r_busy  <= 1'b0;
      r_cmplt <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.iui_special_vsetvl) begin
            r_rs1    <= bus.iui_special_vsetvl_rs1;
            r_rs2    <= bus.iui_special_vsetvl_rs2;
            r_x0     <= bus.iui_special_rs1_x0;
            r_dp     <= bus.iui_special_vsetvl_dp;
            r_vs_off <= bus.regs_special_vs_off;
            r_busy   <= 1'b1;
            r_state  <= S_DEC;
          end
        end
        S_DEC: begin
          if (r_vs_off) begin
            r_expt  <= 1'b1;
            r_wdata <= '0;
            r_cmplt <= 1'b1;
            r_state <= S_WB;
          end else begin
            r_vill  <= w_vill;
            r_vlmax <= w_vlmax;
            r_state <= S_CALC;
          end
        end
        S_CALC: begin
          r_vl    <= w_vl;
          r_vtype <= w_vtype;
          r_wdata <= 64'(w_vl);
          r_expt  <= 1'b0;
          r_cmplt <= 1'b1;
          r_state <= S_WB;
        end
        S_WB: begin
          if (bus.iui_special_wb_ready) begin
            r_cmplt <= 1'b0;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_cmplt <= 1'b0;
        end
      endcase
    end
  end

  // Flush masks completion and commit in the very cycle it is raised
  assign bus.special_iui_vsetvl_busy  = r_busy;
  assign bus.special_iui_vsetvl_cmplt = r_cmplt & ~bus.iui_special_flush;
  assign bus.special_iui_vsetvl_expt  = r_expt;
  assign bus.special_iui_vsetvl_wdata = r_wdata;
  assign bus.special_regs_vsetvl_vld  = (r_state == S_WB) & bus.iui_special_wb_ready
                                        & ~r_expt & ~bus.iui_special_flush;
  assign bus.special_regs_vsetvl_dp   = r_dp;
  assign bus.special_regs_vl          = r_vl;
  assign bus.special_regs_vtype       = r_vtype;

endmodule : aq_cp0_vsetvl_ctrl
`default_nettype wire

// File: tb/tb_aq_cp0_vsetvl_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_aq_cp0_vsetvl_ctrl
// Brief   : Directed self-checking bench for the vsetvl sequencer.
// Revision: 1.0 - initial release
// ============================================================================
module tb_aq_cp0_vsetvl_ctrl;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  aq_cp0_vsetvl_ctrl_if #(.VL_W(8)) bus_if ();

  aq_cp0_vsetvl_ctrl #(.VLEN(128), .VL_W(8)) dut (
    .forever_cpuclk (clk),
    .cpurst_b       (rst_n),
    .bus            (bus_if)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Observations from the last run_op
  int          o_lat, o_vld_cnt, o_vld_lat, o_hold;
  bit          o_unstable;
  logic [63:0] o_wdata, o_vtype;
  logic [7:0]  o_vl;
  logic        o_expt, o_dp;

  // Issue one request and follow it to its handshake, recording what is seen
  task automatic run_op(input logic [63:0] rs1, input logic [63:0] rs2,
                        input logic x0, input logic dp, input logic vs_off,
                        input int ready_delay);
    bit done;
    o_lat = -1; o_vld_cnt = 0; o_vld_lat = -1; o_hold = 0; o_unstable = 0;
    o_wdata = 64'hDEAD_BEEF; o_expt = 1'bx; o_vl = 8'hEE; o_vtype = 64'hEE; o_dp = 1'bx;
    @(negedge clk);
    bus_if.iui_special_vsetvl     = 1'b1;
    bus_if.iui_special_vsetvl_rs1 = rs1;
    bus_if.iui_special_vsetvl_rs2 = rs2;
    bus_if.iui_special_rs1_x0     = x0;
    bus_if.iui_special_vsetvl_dp  = dp;
    bus_if.regs_special_vs_off    = vs_off;
    @(negedge clk);
    bus_if.iui_special_vsetvl  = 1'b0;
    bus_if.regs_special_vs_off = 1'b0;
    done = 0;
    for (int c = 1; c <= 20 && !done; c++) begin
      if (c > 1) @(negedge clk);
      bus_if.iui_special_wb_ready = bus_if.special_iui_vsetvl_cmplt && (o_hold >= ready_delay);
      #1;
      if (bus_if.special_regs_vsetvl_vld) begin
        o_vld_cnt++;
        o_vld_lat = c;
        o_vl    = bus_if.special_regs_vl;
        o_vtype = bus_if.special_regs_vtype;
        o_dp    = bus_if.special_regs_vsetvl_dp;
      end
      if (bus_if.special_iui_vsetvl_cmplt) begin
        if (o_hold == 0) begin
          o_lat   = c;
          o_wdata = bus_if.special_iui_vsetvl_wdata;
          o_expt  = bus_if.special_iui_vsetvl_expt;
        end else if (bus_if.special_iui_vsetvl_wdata !== o_wdata ||
                     bus_if.special_iui_vsetvl_expt !== o_expt) begin
          o_unstable = 1;
        end
        o_hold++;
        if (bus_if.iui_special_wb_ready) done = 1;
      end
    end
    @(posedge clk);
    #1 bus_if.iui_special_wb_ready = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_tests++;
    if (bus_if.special_iui_vsetvl_busy !== 1'b0 || bus_if.special_iui_vsetvl_cmplt !== 1'b0 ||
        bus_if.special_iui_vsetvl_expt !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: busy/cmplt/expt=%b%b%b expected 000", bus_if.special_iui_vsetvl_busy,
               bus_if.special_iui_vsetvl_cmplt, bus_if.special_iui_vsetvl_expt);
    end
    n_tests++;
    if (bus_if.special_iui_vsetvl_wdata !== 64'd0 || bus_if.special_regs_vsetvl_vld !== 1'b0 ||
        bus_if.special_regs_vl !== 8'd0 || bus_if.special_regs_vtype !== 64'd0 ||
        bus_if.special_regs_vsetvl_dp !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_data: wdata=%0h vld=%b vl=%0h vtype=%0h dp=%b expected all 0",
               bus_if.special_iui_vsetvl_wdata, bus_if.special_regs_vsetvl_vld,
               bus_if.special_regs_vl, bus_if.special_regs_vtype, bus_if.special_regs_vsetvl_dp);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    run_op(64'd5, 64'h09, 1'b0, 1'b0, 1'b0, 0);
    n_tests++; if (o_lat !== 3) begin n_fail++; $display("FAIL basic_latency: got %0d expected 3", o_lat); end
    n_tests++; if (o_wdata !== 64'd5) begin n_fail++; $display("FAIL basic_wdata: got %0h expected 5", o_wdata); end
    n_tests++; if (o_expt !== 1'b0) begin n_fail++; $display("FAIL basic_expt: got %b expected 0", o_expt); end
    n_tests++; if (o_vld_cnt !== 1 || o_vld_lat !== 3) begin n_fail++; $display("FAIL basic_vld: count %0d at %0d expected 1 at 3", o_vld_cnt, o_vld_lat); end
    n_tests++; if (o_vl !== 8'd5 || o_vtype !== 64'h09) begin n_fail++; $display("FAIL basic_commit: vl=%0d vtype=%0h expected 5 9", o_vl, o_vtype); end
    @(negedge clk);
    n_tests++; if (bus_if.special_iui_vsetvl_busy !== 1'b0) begin n_fail++; $display("FAIL basic_idle: busy=%b expected 0", bus_if.special_iui_vsetvl_busy); end
  endtask

  task automatic test_saturate();
    run_op(64'd100, 64'h09, 1'b0, 1'b0, 1'b0, 0);
    n_tests++; if (o_wdata !== 64'd8 || o_vl !== 8'd8) begin n_fail++; $display("FAIL sat_100: wdata=%0d vl=%0d expected 8 8", o_wdata, o_vl); end
    run_op(64'h1_0000_0003, 64'h09, 1'b0, 1'b0, 1'b0, 0);
    n_tests++; if (o_wdata !== 64'd8 || o_vl !== 8'd8) begin n_fail++; $display("FAIL sat_upper: wdata=%0d vl=%0d expected 8 8", o_wdata, o_vl); end
    run_op(64'd32, 64'h06, 1'b0, 1'b0, 1'b0, 0);
    n_tests++; if (o_vl !== 8'd32) begin n_fail++; $display("FAIL sat_equal: vl=%0d expected 32", o_vl); end
    run_op(64'd31, 64'h06, 1'b0, 1'b0, 1'b0, 0);
    n_tests++; if (o_vl !== 8'd31 || o_vtype !== 64'h06) begin n_fail++; $display("FAIL sat_below: vl=%0d vtype=%0h expected 31 6", o_vl, o_vtype); end
  endtask

  task automatic test_x0();
    run_op(64'd3, 64'h03, 1'b1, 1'b1, 1'b0, 0);
    n_tests++; if (o_wdata !== 64'd128 || o_vl !== 8'd128) begin n_fail++; $display("FAIL x0_vl: wdata=%0d vl=%0d expected 128 128", o_wdata, o_vl); end
    n_tests++; if (o_dp !== 1'b1) begin n_fail++; $display("FAIL x0_dp: got %b expected 1", o_dp); end
  endtask

  task automatic test_vill();
    run_op(64'd7, 64'h10, 1'b0, 1'b0, 1'b0, 0);
    n_tests++; if (o_wdata !== 64'd0 || o_expt !== 1'b0) begin n_fail++; $display("FAIL vill_sew_wdata: wdata=%0h expt=%b expected 0 0", o_wdata, o_expt); end
    n_tests++; if (o_vld_cnt !== 1 || o_vl !== 8'd0 || o_vtype !== 64'h8000_0000_0000_0000) begin
      n_fail++; $display("FAIL vill_sew_commit: vld=%0d vl=%0d vtype=%0h expected 1 0 8000000000000000", o_vld_cnt, o_vl, o_vtype); end
    run_op(64'd7, 64'h20, 1'b0, 1'b0, 1'b0, 0);
    n_tests++; if (o_vl !== 8'd0 || o_vtype !== 64'h8000_0000_0000_0000) begin n_fail++; $display("FAIL vill_ediv: vl=%0d vtype=%0h expected 0 8000000000000000", o_vl, o_vtype); end
    run_op(64'd7, 64'h100_0000_0009, 1'b0, 1'b0, 1'b0, 0);
    n_tests++; if (o_vl !== 8'd0 || o_vtype !== 64'h8000_0000_0000_0000) begin n_fail++; $display("FAIL vill_high: vl=%0d vtype=%0h expected 0 8000000000000000", o_vl, o_vtype); end
  endtask

  task automatic test_vs_off();
    run_op(64'd5, 64'h09, 1'b0, 1'b0, 1'b1, 0);
    n_tests++; if (o_lat !== 2) begin n_fail++; $display("FAIL vsoff_latency: got %0d expected 2", o_lat); end
    n_tests++; if (o_expt !== 1'b1 || o_wdata !== 64'd0) begin n_fail++; $display("FAIL vsoff_expt: expt=%b wdata=%0h expected 1 0", o_expt, o_wdata); end
    n_tests++; if (o_vld_cnt !== 0) begin n_fail++; $display("FAIL vsoff_vld: got %0d pulses expected 0", o_vld_cnt); end
  endtask

  task automatic test_backpressure();
    run_op(64'd5, 64'h09, 1'b0, 1'b0, 1'b0, 3);
    n_tests++; if (o_hold !== 4 || o_unstable !== 1'b0) begin n_fail++; $display("FAIL bp_hold: held %0d unstable %b expected 4 0", o_hold, o_unstable); end
    n_tests++; if (o_vld_cnt !== 1 || o_vld_lat !== 6) begin n_fail++; $display("FAIL bp_vld: count %0d at %0d expected 1 at 6", o_vld_cnt, o_vld_lat); end
    n_tests++; if (o_wdata !== 64'd5 || o_vl !== 8'd5) begin n_fail++; $display("FAIL bp_data: wdata=%0d vl=%0d expected 5 5", o_wdata, o_vl); end
  endtask

  task automatic test_flush();
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      bus_if.iui_special_vsetvl     = 1'b1;
      bus_if.iui_special_vsetvl_rs1 = 64'd5;
      bus_if.iui_special_vsetvl_rs2 = 64'h09;
      bus_if.iui_special_rs1_x0     = 1'b0;
      @(negedge clk);
      bus_if.iui_special_vsetvl = 1'b0;
      for (int j = 1; j < k; j++) @(negedge clk);
      bus_if.iui_special_flush    = 1'b1;
      bus_if.iui_special_wb_ready = 1'b1;
      #1;
      n_tests++;
      if (bus_if.special_iui_vsetvl_cmplt !== 1'b0 || bus_if.special_regs_vsetvl_vld !== 1'b0) begin
        n_fail++; $display("FAIL flush_mask_%0d: cmplt=%b vld=%b expected 0 0", k,
                           bus_if.special_iui_vsetvl_cmplt, bus_if.special_regs_vsetvl_vld);
      end
      @(negedge clk);
      bus_if.iui_special_flush    = 1'b0;
      bus_if.iui_special_wb_ready = 1'b0;
      #1;
      n_tests++;
      if (bus_if.special_iui_vsetvl_busy !== 1'b0 || bus_if.special_iui_vsetvl_cmplt !== 1'b0) begin
        n_fail++; $display("FAIL flush_idle_%0d: busy=%b cmplt=%b expected 0 0", k,
                           bus_if.special_iui_vsetvl_busy, bus_if.special_iui_vsetvl_cmplt);
      end
    end
    // Flush coincident with a request in IDLE drops the request
    @(negedge clk);
    bus_if.iui_special_vsetvl = 1'b1;
    bus_if.iui_special_flush  = 1'b1;
    @(negedge clk);
    bus_if.iui_special_vsetvl = 1'b0;
    bus_if.iui_special_flush  = 1'b0;
    #1;
    n_tests++; if (bus_if.special_iui_vsetvl_busy !== 1'b0) begin n_fail++; $display("FAIL flush_req_drop: busy=%b expected 0", bus_if.special_iui_vsetvl_busy); end
    run_op(64'd6, 64'h09, 1'b0, 1'b0, 1'b0, 0);
    n_tests++; if (o_lat !== 3 || o_vl !== 8'd6 || o_vld_cnt !== 1) begin n_fail++; $display("FAIL flush_recover: lat=%0d vl=%0d vld=%0d expected 3 6 1", o_lat, o_vl, o_vld_cnt); end
  endtask

  task automatic test_reset_midop();
    int seen;
    seen = 0;
    @(negedge clk);
    bus_if.iui_special_vsetvl     = 1'b1;
    bus_if.iui_special_vsetvl_rs1 = 64'd5;
    bus_if.iui_special_vsetvl_rs2 = 64'h09;
    @(negedge clk);
    bus_if.iui_special_vsetvl = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_tests++; if (bus_if.special_iui_vsetvl_busy !== 1'b0) begin n_fail++; $display("FAIL rst_midop_busy: busy=%b expected 0", bus_if.special_iui_vsetvl_busy); end
    @(negedge clk);
    rst_n = 1'b1;
    bus_if.iui_special_wb_ready = 1'b1;
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      #1;
      if (bus_if.special_iui_vsetvl_cmplt || bus_if.special_regs_vsetvl_vld) seen++;
    end
    bus_if.iui_special_wb_ready = 1'b0;
    n_tests++; if (seen !== 0) begin n_fail++; $display("FAIL rst_midop_quiet: %0d active cycles expected 0", seen); end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    bus_if.iui_special_vsetvl     = 1'b1;
    bus_if.iui_special_vsetvl_rs1 = 64'd7;
    bus_if.iui_special_vsetvl_rs2 = 64'h0C;
    bus_if.iui_special_rs1_x0     = 1'b0;
    @(negedge clk);
    n_tests++; if (bus_if.special_iui_vsetvl_busy !== 1'b1) begin n_fail++; $display("FAIL b2b_busy: busy=%b expected 1", bus_if.special_iui_vsetvl_busy); end
    bus_if.iui_special_vsetvl_rs1 = 64'd1;
    bus_if.iui_special_vsetvl_rs2 = 64'h09;
    @(negedge clk);
    bus_if.iui_special_vsetvl = 1'b0;
    @(negedge clk);
    bus_if.iui_special_wb_ready = 1'b1;
    #1;
    n_tests++;
    if (bus_if.special_iui_vsetvl_cmplt !== 1'b1 || bus_if.special_iui_vsetvl_wdata !== 64'd2 ||
        bus_if.special_regs_vsetvl_vld !== 1'b1 || bus_if.special_regs_vl !== 8'd2) begin
      n_fail++; $display("FAIL b2b_first: cmplt=%b wdata=%0d vld=%b vl=%0d expected 1 2 1 2",
                         bus_if.special_iui_vsetvl_cmplt, bus_if.special_iui_vsetvl_wdata,
                         bus_if.special_regs_vsetvl_vld, bus_if.special_regs_vl);
    end
    @(posedge clk);
    #1 bus_if.iui_special_wb_ready = 1'b0;
    run_op(64'd31, 64'h06, 1'b0, 1'b0, 1'b0, 0);
    n_tests++; if (o_lat !== 3 || o_vl !== 8'd31) begin n_fail++; $display("FAIL b2b_second: lat=%0d vl=%0d expected 3 31", o_lat, o_vl); end
  endtask

  initial begin
    bus_if.iui_special_vsetvl     = 1'b0;
    bus_if.iui_special_vsetvl_rs1 = 64'd0;
    bus_if.iui_special_vsetvl_rs2 = 64'd0;
    bus_if.iui_special_rs1_x0     = 1'b0;
    bus_if.iui_special_vsetvl_dp  = 1'b0;
    bus_if.iui_special_wb_ready   = 1'b0;
    bus_if.iui_special_flush      = 1'b0;
    bus_if.regs_special_vs_off    = 1'b0;
    test_reset();
    test_basic();
    test_saturate();
    test_x0();
    test_vill();
    test_vs_off();
    test_backpressure();
    test_flush();
    test_reset_midop();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_aq_cp0_vsetvl_ctrl
`default_nettype wire
